// File: rtl/updown_counter_param.sv
// ----------------------------------------------------------------------------
// updown_counter_param
//
// General-purpose up/down counter with configurable width and modulus.
// Counts over 0..MAX_VALUE and either wraps or saturates at the range ends.
// Supports synchronous clear, synchronous load (clamped to MAX_VALUE) and a
// count enable. Provides a combinational terminal-count indication, a one-cycle
// wrap pulse and a sticky overflow flag.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   MAX_VALUE  highest count value, 1 <= MAX_VALUE <= 2**WIDTH-1
//   SATURATE   0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous reset, active low
//   clear       in   1      synchronous clear (highest priority)
//   load        in   1      synchronous parallel load
//   load_value  in   WIDTH  value to load (clamped to MAX_VALUE)
//   en          in   1      count enable
//   up          in   1      direction: 1 = increment, 0 = decrement
//   count       out  WIDTH  registered counter value
//   tc          out  1      combinational terminal count for the current direction
//   wrap        out  1      registered pulse, high in the cycle showing a wrapped value
//   overflow    out  1      registered sticky boundary-event flag
// ----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             overflow
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic             at_max;
    logic             at_zero;

    // Out-of-range load values are clamped to the top of the counting range.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
        if ({1'b0, v} > MAX_EXT) begin
            return MAX_W;
        end
        return v;
    endfunction

    // Steps are formed one bit wider than the counter so the boundary is found
    // by comparing against MAX_VALUE (up) or by the borrow bit (down), which
    // keeps non-power-of-two moduli correct.
    always_comb begin
        inc_ext = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
        dec_ext = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};
        at_max  = (inc_ext > MAX_EXT);
        at_zero = dec_ext[WIDTH];
    end

    assign tc = up ? at_max : at_zero;

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        overflow_d = overflow_q;

        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d = clamp_to_max(load_value);
        end else if (en) begin
            if (tc) begin
                overflow_d = 1'b1;
                if (!SATURATE) begin
                    count_d = up ? '0 : MAX_W;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = up ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// ----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Drives three counter instances from one shared stimulus stream:
//   u0: WIDTH=4, MAX_VALUE=15, wrap
//   u1: WIDTH=4, MAX_VALUE=9,  wrap
//   u2: WIDTH=4, MAX_VALUE=9,  saturate
// Each instance is compared against an integer reference model of the counter
// rules, plus a set of literal expectations for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_updown_counter_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       en;
    logic       up;

    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2;
    logic       w0, w1, w2;
    logic       o0, o1, o2;

    updown_counter_param u0 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .en(en), .up(up), .count(c0), .tc(t0), .wrap(w0), .overflow(o0)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .en(en), .up(up), .count(c1), .tc(t1), .wrap(w1), .overflow(o1)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .en(en), .up(up), .count(c2), .tc(t2), .wrap(w2), .overflow(o2)
    );

    int n_chk = 0;
    int errs  = 0;

    int maxv [3] = '{15, 9, 9};
    bit sat  [3] = '{1'b0, 1'b0, 1'b1};

    int m_cnt  [3];
    bit m_wrap [3];
    bit m_ovf  [3];

    function automatic logic [3:0] dut_cnt(input int i);
        case (i)
            0:       return c0;
            1:       return c1;
            default: return c2;
        endcase
    endfunction

    function automatic logic dut_tc(input int i);
        case (i)
            0:       return t0;
            1:       return t1;
            default: return t2;
        endcase
    endfunction

    function automatic logic dut_wrap(input int i);
        case (i)
            0:       return w0;
            1:       return w1;
            default: return w2;
        endcase
    endfunction

    function automatic logic dut_ovf(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    // Next state of each counter from the rules: clear > load > en.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!reset || clear) begin
                m_cnt[i]  = 0;
                m_wrap[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end else if (load) begin
                m_cnt[i]  = (int'(load_value) > maxv[i]) ? maxv[i] : int'(load_value);
                m_wrap[i] = 1'b0;
            end else if (en) begin
                if (up ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0)) begin
                    m_ovf[i] = 1'b1;
                    if (sat[i]) begin
                        m_wrap[i] = 1'b0;
                    end else begin
                        m_cnt[i]  = up ? 0 : maxv[i];
                        m_wrap[i] = 1'b1;
                    end
                end else begin
                    m_cnt[i]  = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    m_wrap[i] = 1'b0;
                end
            end else begin
                m_wrap[i] = 1'b0;
            end
        end
    endtask

    task automatic check_tc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tc[u%0d]", i), 32'(dut_tc(i)),
                32'(up ? (m_cnt[i] == maxv[i]) : (m_cnt[i] == 0)));
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count[u%0d]", i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
            chk($sformatf("wrap[u%0d]", i), 32'(dut_wrap(i)), 32'(m_wrap[i]));
            chk($sformatf("overflow[u%0d]", i), 32'(dut_ovf(i)), 32'(m_ovf[i]));
        end
    endtask

    // Called just after a rising edge with the next inputs already driven.
    task automatic step();
        #1;
        check_tc();
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    // Reset low for 3 ns between clock edges; outputs must clear at once.
    task automatic pulse_reset();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_state();
        #2;
        reset = 1'b1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic [3:0] lv,
                          input logic e, input logic u);
        clear      = c;
        load       = l;
        load_value = lv;
        en         = e;
        up         = u;
    endtask

    initial begin
        int sat_exp [5];
        sat_exp = '{8, 9, 9, 9, 9};

        reset = 1'b0;
        set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        model_reset();
        #1;
        check_state();

        // Reset held for three cycles, en active to show it is ignored.
        en = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Release and count up for 20 cycles.
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 14) begin
                chk("u0_at15", 32'(c0), 32'd15);
                chk("u0_tc15", 32'(t0), 32'd1);
            end
            if (k == 15) begin
                chk("u0_wrap_cnt", 32'(c0), 32'd0);
                chk("u0_wrap_pulse", 32'(w0), 32'd1);
            end
            if (k == 16) chk("u0_wrap_once", 32'(w0), 32'd0);
        end
        chk("u0_ovf_sticky", 32'(o0), 32'd1);

        // Modulo-10 down count from 0.
        set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 11; k++) begin
            step();
            chk("u1_down", 32'(c1), 32'((k == 0 || k == 10) ? 9 : 9 - k));
            chk("u1_down_wrap", 32'(w1), 32'((k == 0 || k == 10) ? 1 : 0));
        end

        // Saturating instance: load 7, five up steps, then twelve down steps.
        set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("u2_sat_up", 32'(c2), 32'(sat_exp[k]));
            chk("u2_no_wrap", 32'(w2), 32'd0);
            if (k == 2) chk("u2_ovf", 32'(o2), 32'd1);
        end
        up = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("u2_sat_low", 32'(c2), 32'd0);

        // Load clamp, clear beats load, load beats a boundary.
        set_in(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        step();
        chk("u0_load12", 32'(c0), 32'd12);
        chk("u1_clamp", 32'(c1), 32'd9);
        set_in(1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        step();
        chk("u1_clr_load", 32'(c1), 32'd0);
        chk("u1_clr_ovf", 32'(o1), 32'd0);
        set_in(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        step();
        chk("u1_load_bnd", 32'(c1), 32'd3);
        chk("u1_load_nowrap", 32'(w1), 32'd0);
        chk("u1_load_noovf", 32'(o1), 32'd0);

        // Asynchronous reset mid-count at 6.
        set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) step();
        chk("u0_pre_rst", 32'(c0), 32'd6);
        pulse_reset();
        step();
        chk("u0_resume1", 32'(c0), 32'd1);
        step();
        chk("u0_resume2", 32'(c0), 32'd2);

        // Direction toggle around 5.
        set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step();
        for (int k = 0; k < 6; k++) begin
            up = (k % 2 == 0);
            step();
            chk("u0_toggle", 32'(c0), 32'((k % 2 == 0) ? 6 : 5));
        end

        // Wrap in flight cancelled by reset: u1 at 9, count up, then reset.
        set_in(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        chk("u1_inflight", 32'(w1), 32'd1);
        pulse_reset();
        chk("u1_cancel", 32'(w1), 32'd0);

        // Randomized traffic, including mid-cycle resets and direction flips.
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom % 20) == 0, ($urandom % 8) == 0, 4'($urandom),
                   ($urandom % 4) != 0, 1'($urandom));
            if (($urandom % 30) == 0) pulse_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errs);
        $finish;
    end

endmodule
